// File: rtl/led_arb_pkg.sv
// Shared constants, FSM state type and index helper for the LED bank arbiter.
package led_arb_pkg;
   localparam int LED_W           = 8;
   localparam int DEF_N_REQ       = 4;
   localparam int DEF_HOLD_CYCLES = 25_000_000;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // Bring an index in [0, 2n) back into [0, n).
   function automatic int wrap_idx(input int i, input int n);
      return (i >= n) ? i - n : i;
   endfunction
endpackage

// File: rtl/led_arb_rr_pick.sv
// Round-robin picker: first requesting index at or after ptr, wrapping to 0.
module led_arb_rr_pick import led_arb_pkg::*; #(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         win,
   output logic                     vld
);
   localparam int PTR_W = $clog2(N_REQ);

   logic [PTR_W-1:0] idx;

   always_comb begin
      win = '0;
      vld = 1'b0;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = PTR_W'(wrap_idx(int'(ptr) + i, N_REQ));
         if (!vld && req[idx]) begin
            win[idx] = 1'b1;
            vld      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter granting the LED bank with a minimum tenure of HOLD_CYCLES.
// Optional LED_ARBITER_IDLE_BLINK_EN: blink o_led[0] every HOLD_CYCLES while idle.
module led_arbiter import led_arb_pkg::*; #(
   parameter int N_REQ       = DEF_N_REQ,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [N_REQ-1:0]            i_req,
   input  logic [N_REQ-1:0][LED_W-1:0] i_data,
   output logic [N_REQ-1:0]            o_grant,
   output logic [LED_W-1:0]            o_led,
   output logic                        o_busy
);
   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   arb_state_e       state_q, state_n;
   logic [N_REQ-1:0] grant_n, win_oh;
   logic [LED_W-1:0] led_n;
   logic [PTR_W-1:0] ptr_q, ptr_n, hold_q, hold_n, win_idx;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             win_vld, grant_new;

   led_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (i_req),
      .ptr (ptr_q),
      .win (win_oh),
      .vld (win_vld)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (win_oh[i]) win_idx = PTR_W'(i);
   end

`ifdef LED_ARBITER_IDLE_BLINK_EN
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_n;
   logic             blink_q, blink_n;
`endif

   always_comb begin
      state_n   = state_q;
      grant_n   = '0;
      led_n     = '0;
      ptr_n     = ptr_q;
      hold_n    = hold_q;
      cnt_n     = cnt_q;
      grant_new = 1'b0;
      case (state_q)
         IDLE: grant_new = win_vld;
         HOLD: begin
            // With ptr at holder+1 the picker only returns the holder when nobody else asks.
            if (!i_req[hold_q])
               state_n = IDLE;
            else if (cnt_q == CNT_MAX && win_vld && win_idx != hold_q)
               grant_new = 1'b1;
            else begin
               grant_n = o_grant;
               led_n   = i_data[hold_q];
               if (cnt_q != CNT_MAX) cnt_n = cnt_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (grant_new) begin
         state_n = HOLD;
         grant_n = win_oh;
         led_n   = i_data[win_idx];
         hold_n  = win_idx;
         ptr_n   = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
         cnt_n   = '0;
      end
`ifdef LED_ARBITER_IDLE_BLINK_EN
      blink_cnt_n = blink_cnt_q;
      blink_n     = blink_q;
      if (grant_new || state_q == HOLD) begin
         blink_cnt_n = '0;
         blink_n     = 1'b0;
      end else begin
         if (blink_cnt_q == CNT_MAX) begin
            blink_cnt_n = '0;
            blink_n     = ~blink_q;
         end else
            blink_cnt_n = blink_cnt_q + 1'b1;
         led_n = {{(LED_W-1){1'b0}}, blink_n};
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         o_grant <= '0;
         o_busy  <= 1'b0;
         o_led   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         o_grant <= grant_n;
         o_busy  <= |grant_n;
         o_led   <= led_n;
         ptr_q   <= ptr_n;
         hold_q  <= hold_n;
         cnt_q   <= cnt_n;
      end
   end

`ifdef LED_ARBITER_IDLE_BLINK_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_n;
         blink_q     <= blink_n;
      end
   end
`endif
endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter: directed scenarios plus random traffic vs a tenure model.
module tb_led_arbiter;
   localparam int N = 4;
   localparam int H = 4;

   logic                i_clk = 1'b0;
   logic                i_rst;
   logic [N-1:0]        i_req;
   logic [N-1:0][7:0]   i_data;
   logic [N-1:0]        o_grant;
   logic [7:0]          o_led;
   logic                o_busy;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: who holds the bank, for how long, and how long we've idled
   bit       m_busy;
   int       m_hold, m_ptr, m_ten, m_idle;
   logic [7:0] m_led;

   led_arbiter #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req   (i_req),
      .i_data  (i_data),
      .o_grant (o_grant),
      .o_led   (o_led),
      .o_busy  (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_scan(input logic [N-1:0] r, input int from);
      for (int k = 0; k < N; k++)
         if (r[(from + k) % N]) return (from + k) % N;
      return -1;
   endfunction

   task automatic m_grant_to(input int w);
      m_busy = 1'b1;
      m_hold = w;
      m_ptr  = (w + 1) % N;
      m_ten  = 0;
      m_idle = 0;
      m_led  = i_data[w];
   endtask

   task automatic model_edge();
      logic [N-1:0] others;
      if (i_rst) begin
         m_busy = 1'b0; m_ptr = 0; m_ten = 0; m_idle = 0; m_led = 8'h00; m_hold = 0;
      end else if (!m_busy) begin
         if (i_req != '0) m_grant_to(rr_scan(i_req, m_ptr));
         else begin
            m_idle++;
`ifdef LED_ARBITER_IDLE_BLINK_EN
            m_led = 8'((m_idle / H) % 2);
`else
            m_led = 8'h00;
`endif
         end
      end else begin
         others = i_req & ~(N'(1) << m_hold);
         if (!i_req[m_hold]) begin
            m_busy = 1'b0; m_idle = 0; m_led = 8'h00;
         end else if (m_ten == H - 1 && others != '0)
            m_grant_to(rr_scan(i_req, m_ptr));
         else begin
            if (m_ten < H - 1) m_ten++;
            m_led = i_data[m_hold];
         end
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      model_edge();
      @(negedge i_clk);
      check("grant", 32'(o_grant), m_busy ? (32'd1 << m_hold) : 32'd0);
      check("busy",  32'(o_busy),  32'(m_busy));
      check("led",   32'(o_led),   32'(m_led));
      check("onehot", 32'($onehot0(o_grant)), 32'd1);
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_req = '0;
      step();
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_req = '0; i_data = '0;
      m_busy = 1'b0; m_hold = 0; m_ptr = 0; m_ten = 0; m_idle = 0; m_led = 8'h00;
      step();
      check("rst_grant", 32'(o_grant), 32'd0);
      check("rst_led",   32'(o_led),   32'd0);
      i_rst = 1'b0;

      // single requester, one-cycle latency to grant and LED
      i_data[2] = 8'hA5; i_req = 4'b0100;
      step();
      check("first_grant", 32'(o_grant), 32'h4);
      check("first_busy",  32'(o_busy),  32'h1);
      check("first_led",   32'(o_led),   32'hA5);

      // all requesting: 4-cycle tenures rotating with no gap
      do_reset();
      i_req = 4'b1111;
      for (int k = 1; k <= 20; k++) begin
         i_data = $urandom();
         step();
         check("rr_seq", 32'(o_grant), 32'd1 << (((k - 1) / H) % N));
      end

      // lone holder persists past the tenure, drops cleanly
      do_reset();
      i_req = 4'b0010;
      for (int k = 0; k < 20; k++) begin
         i_data = $urandom();
         step();
         check("lone_hold", 32'(o_grant), 32'h2);
      end
      i_req = 4'b0000;
      step();
      check("drop_grant", 32'(o_grant), 32'h0);
      check("drop_busy",  32'(o_busy),  32'h0);
      check("drop_led",   32'(o_led),   32'h0);

      // early release forces one idle cycle before the next grant
      do_reset();
      i_req = 4'b1001;
      step();
      step();
      i_req = 4'b1000;
      step();
      check("gap_idle", 32'(o_grant), 32'h0);
      step();
      check("gap_next", 32'(o_grant), 32'h8);

      // reset mid-tenure restarts from pointer 0
      do_reset();
      i_req = 4'b0100;
      step();
      step();
      check("pre_rst", 32'(o_grant), 32'h4);
      i_rst = 1'b1;
      step();
      check("mid_rst_grant", 32'(o_grant), 32'h0);
      check("mid_rst_led",   32'(o_led),   32'h0);
      i_rst = 1'b0; i_req = 4'b1111;
      step();
      check("post_rst", 32'(o_grant), 32'h1);

      // idle LED behaviour after reset
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         step();
`ifdef LED_ARBITER_IDLE_BLINK_EN
         check("idle_led", 32'(o_led), 32'((k / H) % 2));
`else
         check("idle_led", 32'(o_led), 32'd0);
`endif
      end

      // random traffic; requests change occasionally so tenures run out
      do_reset();
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(3) == 0) i_req = N'($urandom());
         i_data = $urandom();
         i_rst  = ($urandom_range(127) == 0);
         step();
      end
      i_rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter HOLD_CYCLES, default 25_000_000, minimum grant tenure in i_clk cycles (>=1).
REQ-003 SHALL provide port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL provide port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port i_req  input  N_REQ  per-requester request for the LED bank.
REQ-006 SHALL provide port i_data  input  N_REQ x 8  per-requester LED pattern.
REQ-007 SHALL provide port o_grant  output  N_REQ  one-hot grant, all-zero when idle.
REQ-008 SHALL provide port o_led  output  8  registered LED drive.
REQ-009 SHALL provide port o_busy  output  1  high while any grant is active.

Function
REQ-010 SHALL implement FSM states IDLE and HOLD; reset state IDLE.
REQ-011 IDLE: any i_req at cycle N -> state HOLD, o_grant one-hot for the winner at N+1, hold counter cleared to 0.
REQ-012 Winner SHALL be the first requesting index at or after the round-robin pointer, wrapping N_REQ-1 -> 0.
REQ-013 On each grant the pointer SHALL become (winner+1) mod N_REQ.
REQ-014 In HOLD, o_led SHALL register i_data[granted] every cycle (one-cycle latency from i_data to o_led).
REQ-015 Hold counter SHALL increment every HOLD cycle, saturating at HOLD_CYCLES-1.
REQ-016 Counter at HOLD_CYCLES-1 and another requester active: SHALL re-grant directly to the round-robin winner next cycle, counter to 0, no IDLE gap.
REQ-017 Counter at HOLD_CYCLES-1 and only the holder requesting: grant SHALL persist unchanged.
REQ-018 Holder deasserting i_req at any counter value: next cycle o_grant=0, state IDLE, no arbitration that cycle, even if others request.
REQ-019 o_busy SHALL equal OR of o_grant (registered, same cycle as o_grant).
REQ-020 In IDLE, o_led SHALL be 8'h00 (except as REQ-024).
REQ-021 o_grant SHALL never have more than one bit set.

Reset
REQ-022 i_rst high at an edge SHALL force: state IDLE, o_grant=0, o_busy=0, o_led=8'h00, pointer=0, hold counter=0, blink counter=0.
REQ-023 Reset asserted mid-HOLD SHALL take priority over every transition; first grant after release SHALL follow REQ-011 with pointer 0.

Configuration
REQ-024 With macro LED_ARBITER_IDLE_BLINK_EN defined: in IDLE, o_led[0] SHALL toggle every HOLD_CYCLES cycles (other bits 0), blink state cleared on each grant; undefined: no blink counter, o_led=8'h00 in IDLE.

Structure
REQ-025 Package led_arb_pkg SHALL hold LED_W=8, the FSM state enum typedef, and default N_REQ/HOLD_CYCLES constants.
REQ-026 Sub-module led_arb_rr_pick (combinational: req vector + pointer -> one-hot winner + valid) SHALL implement REQ-012.

Verification (bench HOLD_CYCLES=4, N_REQ=4)
REQ-027 Reset, then i_req=4'b0100, i_data[2]=8'hA5 at N -> o_grant=4'b0100, o_busy=1 at N+1; o_led=8'hA5 at N+1.
REQ-028 i_req=4'b1111 held -> grants 0001,0010,0100,1000,0001 each lasting exactly 4 cycles, no gap cycles.
REQ-029 Only req[1] held 20 cycles -> o_grant=4'b0010 continuously; then drop req[1] -> o_grant=0, o_busy=0, o_led=8'h00 next cycle.
REQ-030 Holder 0 drops at counter 1 while req[3]=1 -> one IDLE cycle with o_grant=0, then o_grant=4'b1000.
REQ-031 i_rst pulsed mid-HOLD with grant 4'b0100 -> all outputs 0 next cycle; then i_req=4'b1111 -> first grant 4'b0001.
REQ-032 With LED_ARBITER_IDLE_BLINK_EN, no requests 16 cycles after reset -> o_led[0] toggles at cycles 4,8,12,16; o_led[7:1]=0.
